// File: rtl/led_blink_mc_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
package led_pkg;

  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_BLINK, LED_BURST} led_mode_t;

  typedef enum logic [1:0] {CH_IDLE, CH_RUN, CH_DONE} chan_state_t;

  // Out-of-range divider selects saturate at the counter MSB instead of wrapping.
  function automatic int clamp_div(input int div, input int cnt_w);
    return (div > cnt_w - 1) ? cnt_w - 1 : div;
  endfunction

endpackage

// File: rtl/led_blink_mc_chan.sv
// One LED channel: latched config, period counter, burst FSM, output register.
module led_chan
  import led_pkg::*;
#(
  parameter int DIV_W   = 5,
  parameter int CNT_W   = 32,
  parameter int BURST_W = 4
) (
  input  logic               clk100,
  input  logic               rstn,
  input  logic               tick,
  input  logic               wren,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [1:0]         mode_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic               led_o,
  output logic               busy_o
);

  localparam int IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

  led_mode_t          mode_q;
  logic [DIV_W-1:0]   div_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] pcnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   div_eff;
  chan_state_t        state_q, state_d;
  logic               led_q, led_d;
  logic               run_cnt;
  logic               fall;
  logic               last_period;

  assign div_eff     = IDX_W'(clamp_div(32'(div_q), CNT_W));
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign run_cnt     = (mode_q == LED_BLINK) || (mode_q == LED_BURST && state_q == CH_RUN);
  // A period ends when the selected bit drops 1->0 as the counter advances.
  assign fall        = tick && run_cnt && cnt_q[div_eff] && !cnt_inc[div_eff];
  assign last_period = (pcnt_q + BURST_W'(1)) == burst_q;

  // Config latch, counter and period count; a load overrides any completion.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= LED_OFF;
      div_q   <= '0;
      burst_q <= '0;
      pcnt_q  <= '0;
      cnt_q   <= '0;
    end else if (wren) begin
      mode_q  <= led_mode_t'(mode_i);
      div_q   <= div_i;
      burst_q <= burst_i;
      pcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (run_cnt && tick) cnt_q <= cnt_inc;
      if (state_q == CH_RUN && fall) pcnt_q <= pcnt_q + BURST_W'(1);
    end
  end

  // FSM state and registered LED drive.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      state_q <= CH_IDLE;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  // Next state and LED value derived from the current channel state.
  always_comb begin
    state_d = state_q;
    led_d   = 1'b0;
    if (wren) begin
      if (mode_i == LED_BURST) state_d = (burst_i != '0) ? CH_RUN : CH_DONE;
      else                     state_d = CH_IDLE;
    end else if (state_q == CH_RUN && fall && last_period) begin
      state_d = CH_DONE;
    end
    case (mode_q)
      LED_OFF:   led_d = 1'b0;
      LED_ON:    led_d = 1'b1;
      LED_BLINK: led_d = cnt_q[div_eff];
      LED_BURST: led_d = (state_q == CH_RUN) && cnt_q[div_eff];
      default:   led_d = 1'b0;
    endcase
  end

  assign led_o  = led_q;
  assign busy_o = (state_q == CH_RUN);

endmodule

// File: rtl/led_blink_mc.sv
// Multi-channel LED blinker: shared prescaler plus N_CH independent channels.
module led_blink_mc
  import led_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int DIV_W    = 5,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1,
  parameter int BURST_W  = 4
) (
  input  logic               clk100,
  input  logic               rstn,
  input  logic [N_CH-1:0]    wren_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic [1:0]         mode_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [N_CH-1:0]    led_o,
  output logic [N_CH-1:0]    busy_o
);

  logic tick;

  generate
    if (PRESCALE <= 1) begin : g_no_ps
      assign tick = 1'b1;
    end else begin : g_ps
      localparam int PS_W = $clog2(PRESCALE);
      logic [PS_W-1:0] ps_q;
      // Free-running prescaler; writes never disturb it so ticks stay evenly spaced.
      always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn)                            ps_q <= '0;
        else if (ps_q == PS_W'(PRESCALE - 1)) ps_q <= '0;
        else                                  ps_q <= ps_q + PS_W'(1);
      end
      assign tick = (ps_q == PS_W'(PRESCALE - 1));
    end
  endgenerate

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      led_chan #(
        .DIV_W   (DIV_W),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
      ) u_chan (
        .clk100  (clk100),
        .rstn    (rstn),
        .tick    (tick),
        .wren    (wren_i[c]),
        .div_i   (div_i),
        .mode_i  (mode_i),
        .burst_i (burst_i),
        .led_o   (led_o[c]),
        .busy_o  (busy_o[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_led_blink_mc.sv
// Directed bench for led_blink_mc (CNT_W=8, plus a PRESCALE=4 instance).
module tb_led_blink_mc;

  logic       clk100 = 1'b0;
  logic       rstn   = 1'b0;
  logic [1:0] wren_i = '0;
  logic [4:0] div_i  = '0;
  logic [1:0] mode_i = '0;
  logic [3:0] burst_i = '0;
  logic [1:0] led_o, busy_o;

  logic [1:0] wren2 = '0;
  logic [4:0] div2  = '0;
  logic [1:0] mode2 = '0;
  logic [3:0] burst2 = '0;
  logic [1:0] led2, busy2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk100 = ~clk100;

  led_blink_mc #(.N_CH(2), .DIV_W(5), .CNT_W(8), .PRESCALE(1), .BURST_W(4)) u_dut (
    .clk100(clk100), .rstn(rstn), .wren_i(wren_i), .div_i(div_i), .mode_i(mode_i),
    .burst_i(burst_i), .led_o(led_o), .busy_o(busy_o));

  led_blink_mc #(.N_CH(2), .DIV_W(5), .CNT_W(8), .PRESCALE(4), .BURST_W(4)) u_dut_ps4 (
    .clk100(clk100), .rstn(rstn), .wren_i(wren2), .div_i(div2), .mode_i(mode2),
    .burst_i(burst2), .led_o(led2), .busy_o(busy2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic bitof(input int v, input int b);
    return 1'((v >> b) & 1);
  endfunction

  // Loads on the next posedge; returns at the negedge right after the load edge.
  task automatic wr(input logic [1:0] m, input logic [1:0] md, input logic [4:0] d, input logic [3:0] b);
    @(negedge clk100);
    wren_i = m; mode_i = md; div_i = d; burst_i = b;
    @(negedge clk100);
    wren_i = '0; mode_i = 2'd0; div_i = 5'd31; burst_i = 4'd15;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk100);
  endtask

  logic s [16];

  initial begin
    // Reset state
    step(3);
    chk("rst_led", 32'(led_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("idle_led", 32'(led_o), 0);
      chk("idle_busy", 32'(busy_o), 0);
    end

    // ch0 ON, then BLINK div=2
    wr(2'b01, 2'd1, 5'd0, 4'd0);
    step(1);
    chk("on_led0", 32'(led_o[0]), 1);
    chk("on_led1", 32'(led_o[1]), 0);
    wr(2'b01, 2'd2, 5'd2, 4'd0);
    for (int j = 1; j <= 16; j++) begin
      step(1);
      chk("blink_div2", 32'(led_o[0]), 32'(bitof(j - 1, 2)));
      chk("blink_led1", 32'(led_o[1]), 0);
    end

    // ch1 BURST div=1 burst=3
    wr(2'b10, 2'd3, 5'd1, 4'd3);
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) step(1);
      chk("burst_busy1", 32'(busy_o[1]), (j < 12) ? 1 : 0);
      chk("burst_led1", 32'(led_o[1]), (j >= 1 && j <= 12) ? 32'(bitof(j - 1, 1)) : 0);
    end

    // Divider clamp: div=31 and div=9 both select bit 7
    wr(2'b01, 2'd2, 5'd31, 4'd0);
    for (int j = 1; j <= 257; j++) begin
      step(1);
      if (j == 1 || j == 128 || j == 129 || j == 256 || j == 257)
        chk("clamp31", 32'(led_o[0]), 32'(bitof(j - 1, 7)));
    end
    wr(2'b01, 2'd2, 5'd9, 4'd0);
    for (int j = 1; j <= 129; j++) begin
      step(1);
      if (j == 3 || j == 128 || j == 129)
        chk("clamp9", 32'(led_o[0]), 32'(bitof(j - 1, 7)));
    end

    // Phase-aligned dual write
    wr(2'b11, 2'd2, 5'd1, 4'd0);
    for (int j = 1; j <= 16; j++) begin
      step(1);
      chk("aligned", 32'(led_o[0]), 32'(led_o[1]));
      chk("aligned_val", 32'(led_o[0]), 32'(bitof(j - 1, 1)));
    end

    // Dual burst, then abort ch0 with BURST burst=0
    wr(2'b11, 2'd3, 5'd1, 4'd5);
    step(5);
    chk("dual_busy", 32'(busy_o), 32'h3);
    wr(2'b01, 2'd3, 5'd1, 4'd0);
    chk("abort_busy", 32'(busy_o), 32'h2);
    step(1);
    chk("abort_led0", 32'(led_o[0]), 0);
    chk("ch1_led_pre", 32'(led_o[1]), 1);
    chk("ch1_busy_pre", 32'(busy_o[1]), 1);

    // Asynchronous reset mid-burst
    #2 rstn = 1'b0;
    #1;
    chk("async_led", 32'(led_o), 0);
    chk("async_busy", 32'(busy_o), 0);
    @(negedge clk100);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("post_rst_led", 32'(led_o), 0);
      chk("post_rst_busy", 32'(busy_o), 0);
    end

    // PRESCALE=4, div=0: period 8 cycles
    @(negedge clk100);
    wren2 = 2'b01; mode2 = 2'd2; div2 = 5'd0; burst2 = 4'd0;
    @(negedge clk100);
    wren2 = '0; mode2 = 2'd0; div2 = 5'd31;
    step(10);
    for (int t = 0; t < 16; t++) begin
      step(1);
      s[t] = led2[0];
    end
    for (int t = 0; t < 8; t++) begin
      chk("ps4_period", 32'(s[t]), 32'(s[t + 8]));
      chk("ps4_half", 32'(s[t] ^ s[t + 4]), 1);
    end
    chk("ps4_led1", 32'(led2[1]), 0);
    chk("ps4_busy", 32'(busy2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_blink_mc.md
Name: led_blink_mc

Overview:
- Multi-channel, parametrised successor to the single-LED divider/blinker (led_cnt).
- Drives N_CH LED outputs. Each channel is independently programmable to one of four modes: OFF, ON, continuous BLINK, or finite BURST.
- Each channel has its own divider, its own write-enable and a busy flag.
- Sits beside the block design in the top-level IO wrapper and drives board LEDs from the clk100 domain.

Parameters:
- N_CH, 2, number of LED channels.
- DIV_W, 5, width of the divider select input.
- CNT_W, 32, width of each channel's period counter.
- PRESCALE, 1, clk100 cycles per counting tick. Legal range 1..2^16.
- BURST_W, 4, width of the burst-count input.

Ports:
- clk100  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- wren_i  in  N_CH  per-channel configuration load strobe, one-cycle pulse.
- div_i  in  DIV_W  selects which counter bit drives the LED.
- mode_i  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- burst_i  in  BURST_W  number of complete blink periods in BURST mode.
- led_o  out  N_CH  LED drive, registered.
- busy_o  out  N_CH  high while a channel is in an unfinished burst.

Behaviour:
- Clock and reset: one clock, clk100. Reset rstn is asynchronous, active-low.
- Reset values: led_o=0, busy_o=0. Every channel: mode=OFF, div=0, burst count=0, counter=0. Prescaler=0.
- Prescaler:
  - Shared free-running counter of width clog2(PRESCALE).
  - tick=1 on the cycle it wraps. With PRESCALE=1, tick=1 every cycle.
  - The prescaler is never reset by writes.
- Configuration load:
  - On an edge with wren_i[c]=1, channel c latches div_i, mode_i and burst_i, and clears counter c to 0.
  - Several wren_i bits high together load identical configuration into each selected channel; those channels are then phase-aligned.
- Divider select: div_eff = min(div, CNT_W-1). Out-of-range selects clamp to the MSB; there is no wrap.
- Counter: cnt increments by 1 on each tick in BLINK and BURST, wraps modulo 2^CNT_W, and holds in OFF and ON.
- Output per mode (led_o registered; led_o lags the cnt/mode state by 1 cycle):
  - OFF: led_o=0.
  - ON: led_o=1.
  - BLINK or BURST: led_o = cnt[div_eff].
- Period length: (2^(div_eff+1))·PRESCALE cycles, 50% duty.
- Channel state machine, states IDLE, RUN, DONE:
  - IDLE: mode OFF, ON or BLINK; busy_o=0.
  - Load with mode=BURST and burst_i>0 -> RUN; busy_o=1 from the cycle after the load.
  - Load with mode=BURST and burst_i=0 -> DONE immediately; led 0, busy 0.
  - RUN: a period completes when cnt[div_eff] falls 1->0 on a tick. The period counter increments on each completion.
  - When the period count reaches burst -> DONE: cnt holds, and led_o=0 and busy_o=0 on the following cycle.
  - DONE: led 0, busy 0 until the next load to that channel.
- Load during RUN aborts the burst and applies the new configuration; a new BURST restarts the period count from 0.
- wren_i on the same edge as a period completion: the load wins, and the completion is discarded.
- Reset asserted mid-operation: outputs go to 0 asynchronously. After rstn rises, every channel is in IDLE/OFF until written.
- div, mode and burst are not sampled except on wren_i; changing those inputs without wren_i has no effect.

Decomposition:
- Package led_pkg holds:
  - typedef enum logic [1:0] led_mode_t {LED_OFF, LED_ON, LED_BLINK, LED_BURST};
  - typedef enum chan_state_t {CH_IDLE, CH_RUN, CH_DONE};
  - function clamp_div.
- One sub-module, led_chan: per-channel registers, counter, FSM and output register. It takes tick as an input.
- The top level holds the prescaler and a generate loop over N_CH instances of led_chan.

Test Plan (CNT_W=8, PRESCALE=1 unless stated):
- Reset release, no writes -> led_o=0 and busy_o=0 for 100 cycles.
- ch0 write mode=ON -> led_o[0]=1 one cycle after the load. Then write mode=BLINK div=2 -> led_o[0] starts low, then alternates 4 cycles high / 4 cycles low (period 8). led_o[1] stays 0.
- ch1 write BURST div=1 burst=3 -> busy_o[1]=1 for 12 cycles, led_o[1] shows 3 pulses of 2 high / 2 low, then led_o[1]=0 and busy_o[1]=0 permanently.
- ch0 write BLINK div=31 -> clamped to bit 7, period 256 cycles. Repeat with PRESCALE=4 and div=0 -> period 8 cycles.
- wren_i=2'b11 with BLINK div=1 -> led_o[0]==led_o[1] on every cycle. Then rewrite ch0 mid-burst with BURST burst=0 -> led_o[0]=0 and busy_o[0]=0 the next cycle.
- rstn pulled low mid-burst on ch1 -> led_o and busy_o go to 0 without waiting for a clock edge, and stay 0 after release until a new write.
